key_debounce_array: RTL and testbench
=====================================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N, default 8: number of independent key channels, N >= 1.
REQ-002 Parameter D, default 22: counter width; stability threshold T = 2^(D-1) cycles; D >= 2 (D = 2, T = 2 for bench runs).
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 INPUT  input  N  raw (bouncing) key inputs, one bit per channel.
REQ-006 EN  input  N  per-channel enable; 0 holds channel idle.
REQ-007 D_OUT  output  N  registered debounced level per channel.
REQ-008 PRESS  output  N  registered one-cycle pulse on D_OUT 0->1 per channel.
REQ-009 RELEASE  output  N  registered one-cycle pulse on D_OUT 1->0 per channel.
REQ-010 ANY_ACTIVE  output  1  combinational OR of all D_OUT bits.

Function
REQ-011 Each channel shall be independent: own sample path, own D-bit counter, own D_OUT/PRESS/RELEASE; no cross-channel interaction except ANY_ACTIVE.
REQ-012 Sampled value S[i] shall be the synchroniser output (see Configuration).
REQ-013 With EN[i]=1 and S[i]==D_OUT[i], counter shall clear to 0.
REQ-014 With EN[i]=1 and S[i]!=D_OUT[i] and counter < T-1, counter shall increment by 1.
REQ-015 With EN[i]=1, S[i]!=D_OUT[i] and counter == T-1, D_OUT[i] shall load S[i] and counter shall clear to 0 on that edge; D_OUT changes on the T-th consecutive edge of mismatch.
REQ-016 Any single cycle of S[i]==D_OUT[i] during a mismatch run shall restart the run from 0 (glitch rejection).
REQ-017 Counter shall never exceed T-1 and shall never wrap.
REQ-018 PRESS[i] shall be 1 for exactly the cycle following the edge where D_OUT[i] went 0->1; RELEASE[i] likewise for 1->0; otherwise 0; PRESS[i] and RELEASE[i] never both 1.
REQ-019 With EN[i]=0: counter cleared; D_OUT[i] forced to 0 on next edge; if D_OUT[i] was 1, RELEASE[i] pulses once; synchroniser flops keep sampling.
REQ-020 EN[i] 0->1 with S[i]=1 shall start a normal mismatch run from counter 0 (press after T edges).
REQ-021 Simultaneous transitions on multiple channels shall produce simultaneous PRESS/RELEASE pulses on all affected channels in the same cycle.

Reset
REQ-022 RESET_N=0 shall asynchronously clear synchroniser flops, counters, D_OUT, PRESS, RELEASE to 0.
REQ-023 Reset asserted mid-run shall discard the partial count; no PRESS/RELEASE pulse shall be generated by reset itself.
REQ-024 After RESET_N deasserts with INPUT[i] held 1, D_OUT[i] shall rise after the normal latency and PRESS[i] shall pulse once.

Configuration
REQ-025 Macro DEBOUNCE_SYNC_EN defined: S[i] = second stage of a two-flop synchroniser on INPUT[i]; INPUT-to-D_OUT latency = T+2 edges (first edge sampling new value counts as edge 1).
REQ-026 DEBOUNCE_SYNC_EN undefined: synchroniser omitted, S[i] = INPUT[i] directly (caller supplies synchronous inputs); latency = T edges; all other behaviour identical.

Verification (N=4, D=2, T=2, DEBOUNCE_SYNC_EN defined unless stated)
REQ-027 INPUT[0] 0->1 held, EN=4'hF -> D_OUT[0]=1 after 4th edge, PRESS=4'b0001 for exactly one following cycle, ANY_ACTIVE=1.
REQ-028 INPUT[1] pulsed high for 1 cycle, then low 3 cycles, repeated 5 times -> D_OUT[1] stays 0, PRESS[1] never asserts.
REQ-029 INPUT=4'hF applied in one cycle, held, then 4'h0 held -> PRESS=4'hF single cycle, later RELEASE=4'hF single cycle, same cycle for all channels.
REQ-030 D_OUT[2]=1 stable, EN[2] driven 0 -> D_OUT[2]=0 next edge, RELEASE[2] one pulse; EN[2] back to 1 with INPUT[2]=1 -> PRESS[2] after 2 edges.
REQ-031 RESET_N pulsed low mid-count and mid-PRESS pulse -> all outputs 0 immediately (no clock edge needed), no pulses on deassert until a fresh run completes.
REQ-032 Macro undefined, INPUT[3] 0->1 held -> D_OUT[3]=1 after 2nd edge, PRESS[3] one cycle.

Source files
------------

// File: rtl/key_debounce_array.sv
// ============================================================================
// Module   : key_debounce_array
// Purpose  : N-channel key debouncer with per-channel enable and press/release
//            pulses. Optional two-flop input synchroniser via DEBOUNCE_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_array #(
  parameter int N = 8,
  parameter int D = 22
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [N-1:0] INPUT,
  input  logic [N-1:0] EN,
  output logic [N-1:0] D_OUT,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic         ANY_ACTIVE
);

  // Terminal count T-1 = 2^(D-1)-1
  localparam logic [D-1:0] c_TMAX = {1'b0, {(D-1){1'b1}}};

  generate
    for (genvar i = 0; i < N; i++) begin : g_ch
      logic         w_s;
      logic [D-1:0] r_cnt;
      logic         r_dout;
      logic         r_press;
      logic         r_rel;

`ifdef DEBOUNCE_SYNC_EN
      logic [1:0] r_sync;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_sync <= 2'b00;
        end else begin
          r_sync <= {r_sync[0], INPUT[i]};
        end
      end

      assign w_s = r_sync[1];
`else
      assign w_s = INPUT[i];
`endif

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_cnt   <= '0;
          r_dout  <= 1'b0;
          r_press <= 1'b0;
          r_rel   <= 1'b0;
        end else begin
          r_press <= 1'b0;
          r_rel   <= 1'b0;
          if (!EN[i]) begin
            // Disabled channel drops to idle, reporting a release if it was high
            r_cnt  <= '0;
            r_dout <= 1'b0;
            r_rel  <= r_dout;
          end else if (w_s == r_dout) begin
            r_cnt <= '0;
          end else if (r_cnt == c_TMAX) begin
            r_cnt   <= '0;
            r_dout  <= w_s;
            r_press <= w_s;
            r_rel   <= ~w_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign D_OUT[i]   = r_dout;
      assign PRESS[i]   = r_press;
      assign RELEASE[i] = r_rel;
    end
  endgenerate

  assign ANY_ACTIVE = |D_OUT;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_array.sv
// ============================================================================
// Module   : tb_key_debounce_array
// Purpose  : Directed self-checking bench for key_debounce_array (N=4, D=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_array;

  localparam int N = 4;
  localparam int D = 2;
  localparam int T = 2;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = T + 2;
`else
  localparam int LAT = T;
`endif

  logic         CLK;
  logic         RESET_N;
  logic [N-1:0] INPUT;
  logic [N-1:0] EN;
  logic [N-1:0] D_OUT;
  logic [N-1:0] PRESS;
  logic [N-1:0] RELEASE;
  logic         ANY_ACTIVE;

  int checks   = 0;
  int failures = 0;

  key_debounce_array #(.N(N), .D(D)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .INPUT      (INPUT),
    .EN         (EN),
    .D_OUT      (D_OUT),
    .PRESS      (PRESS),
    .RELEASE    (RELEASE),
    .ANY_ACTIVE (ANY_ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] dout,
                           input logic [N-1:0] press, input logic [N-1:0] rel);
    check({tag, ".dout"}, D_OUT, dout);
    check({tag, ".press"}, PRESS, press);
    check({tag, ".release"}, RELEASE, rel);
    check({tag, ".any"}, {3'b000, ANY_ACTIVE}, {3'b000, |dout});
  endtask

  initial begin
    RESET_N = 1'b0;
    INPUT   = 4'h0;
    EN      = 4'hF;
    tick(2);
    check_all("reset", 4'h0, 4'h0, 4'h0);
    RESET_N = 1'b1;
    tick(2);
    check_all("idle", 4'h0, 4'h0, 4'h0);

    // Single-channel press and release
    INPUT = 4'b0001;
    tick(LAT - 1);
    check_all("press0_early", 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("press0", 4'b0001, 4'b0001, 4'h0);
    tick(1);
    check_all("press0_after", 4'b0001, 4'h0, 4'h0);
    INPUT = 4'b0000;
    tick(LAT - 1);
    check_all("rel0_early", 4'b0001, 4'h0, 4'h0);
    tick(1);
    check_all("rel0", 4'h0, 4'h0, 4'b0001);
    tick(1);
    check_all("rel0_after", 4'h0, 4'h0, 4'h0);

    // Glitch rejection: 1-cycle pulses on channel 1
    for (int r = 0; r < 5; r++) begin
      INPUT = 4'b0010;
      tick(1);
      check("glitch_dout", D_OUT, 4'h0);
      INPUT = 4'b0000;
      for (int q = 0; q < 3; q++) begin
        tick(1);
        check("glitch_press", PRESS, 4'h0);
      end
    end
    check_all("glitch_end", 4'h0, 4'h0, 4'h0);

    // All channels together
    INPUT = 4'hF;
    tick(LAT);
    check_all("all_press", 4'hF, 4'hF, 4'h0);
    tick(1);
    check_all("all_press_after", 4'hF, 4'h0, 4'h0);
    INPUT = 4'h0;
    tick(LAT);
    check_all("all_rel", 4'h0, 4'h0, 4'hF);
    tick(1);
    check_all("all_rel_after", 4'h0, 4'h0, 4'h0);

    // Enable drop and restore on channel 2
    INPUT = 4'b0100;
    tick(LAT + 1);
    check_all("ch2_high", 4'b0100, 4'h0, 4'h0);
    EN = 4'b1011;
    tick(1);
    check_all("en_drop", 4'h0, 4'h0, 4'b0100);
    tick(1);
    check_all("en_drop_after", 4'h0, 4'h0, 4'h0);
    EN = 4'hF;
    tick(1);
    check_all("en_restore_1", 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("en_restore_2", 4'b0100, 4'b0100, 4'h0);
    INPUT = 4'b0000;
    tick(LAT);
    check_all("ch2_rel", 4'h0, 4'h0, 4'b0100);
    tick(1);

    // Asynchronous reset during a PRESS pulse
    INPUT = 4'b0001;
    tick(LAT);
    check_all("pre_reset_press", 4'b0001, 4'b0001, 4'h0);
    #2;
    RESET_N = 1'b0;
    #1;
    check_all("async_reset_pulse", 4'h0, 4'h0, 4'h0);
    tick(1);
    RESET_N = 1'b1;
    tick(LAT - 1);
    check_all("post_reset_early", 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("post_reset_press", 4'b0001, 4'b0001, 4'h0);
    tick(1);

    // Asynchronous reset mid-count discards progress
    INPUT = 4'b0011;
    tick(LAT - 1);
    check_all("midcount", 4'b0001, 4'h0, 4'h0);
    #2;
    RESET_N = 1'b0;
    #1;
    check_all("async_reset_count", 4'h0, 4'h0, 4'h0);
    tick(1);
    RESET_N = 1'b1;
    tick(LAT - 1);
    check_all("recount_early", 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("recount_press", 4'b0011, 4'b0011, 4'h0);
    tick(1);
    check_all("recount_after", 4'b0011, 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
